// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: reads BYTES_PER_INSTR bytes from a synchronous-read
// byte memory, assembles them little-endian, and hands the word over valid/ready.
// Optional macro IFETCH_WRAP_ERR_EN adds instr_wrap_err (fetch wrapped past top of memory).
`timescale 1ns/1ps
module instr_fetch_responder #(
    parameter int ADDR_W          = 5,
    parameter int BYTES_PER_INSTR = 2,
    parameter int DATA_W          = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              addr_valid,
    input  logic [ADDR_W-1:0]                 addr,
    output logic                              addr_ready,
    output logic                              mem_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              instr_valid,
    output logic [BYTES_PER_INSTR*DATA_W-1:0] instr,
    output logic [ADDR_W-1:0]                 instr_addr,
    input  logic                              instr_ready
`ifdef IFETCH_WRAP_ERR_EN
    ,
    output logic                              instr_wrap_err
`endif
);

    localparam int B     = BYTES_PER_INSTR;
    localparam int IDX_W = (B > 1) ? $clog2(B) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);

    typedef enum logic [1:0] {IDLE, READ, LAST, HOLD} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg;
    logic [ADDR_W-1:0]       base_reg;
    logic [ADDR_W-1:0]       instr_addr_reg;
    logic [DATA_W-1:0]       bytes_reg [B];
    logic [B*DATA_W-1:0]     instr_reg;
    logic [B*DATA_W-1:0]     instr_assembled;
    logic                    accept;
    logic                    capture;
    logic                    finish;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Accept is gated by rst so outputs sit at reset values while reset is held.
    always_comb begin
        state_next = state_reg;
        addr_ready = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                addr_ready = 1'b1;
                if (rst && addr_valid) begin
                    accept     = 1'b1;
                    mem_en     = 1'b1;
                    mem_addr   = addr;
                    state_next = (B == 1) ? LAST : READ;
                end
            end
            READ: begin
                mem_en   = 1'b1;
                mem_addr = base_reg + ADDR_W'(idx_reg);
                capture  = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = LAST;
                end
            end
            LAST: begin
                finish     = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The final byte comes straight off the memory bus in LAST.
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_slot
            if (gi == B - 1) begin : g_tail
                assign instr_assembled[gi*DATA_W +: DATA_W] = mem_rdata;
            end else begin : g_body
                assign instr_assembled[gi*DATA_W +: DATA_W] = bytes_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_reg        <= '0;
            base_reg       <= '0;
            instr_reg      <= '0;
            instr_addr_reg <= '0;
        end else begin
            if (accept) begin
                base_reg <= addr;
                idx_reg  <= IDX_W'(1);
            end
            if (capture) begin
                bytes_reg[idx_reg - IDX_W'(1)] <= mem_rdata;
                idx_reg                        <= idx_reg + IDX_W'(1);
            end
            if (finish) begin
                instr_reg      <= instr_assembled;
                instr_addr_reg <= base_reg;
                idx_reg        <= '0;
            end
        end
    end

`ifdef IFETCH_WRAP_ERR_EN
    logic              wrap_err_reg;
    logic [ADDR_W:0]   end_addr;

    assign end_addr = {1'b0, base_reg} + (ADDR_W+1)'(B - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_err_reg <= 1'b0;
        end else if (accept) begin
            wrap_err_reg <= 1'b0;
        end else if (finish) begin
            wrap_err_reg <= end_addr[ADDR_W];
        end
    end

    assign instr_wrap_err = wrap_err_reg;
`endif

    assign instr_valid = (state_reg == HOLD);
    assign instr       = instr_reg;
    assign instr_addr  = instr_addr_reg;

endmodule
